// File: rtl/eco32f_pkg.sv
// eco32f_pkg: shared constants and types for the ECO32F write-back stage.
// Holds the exception link register index, default widths and the
// write-port source select enum used by eco32f_writeback_q.
package eco32f_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int AW_DEFAULT   = 5;
    localparam int EXC_LINK_REG = 30;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_EXC   = 2'd1,
        SRC_PIPE  = 2'd2,
        SRC_QUEUE = 2'd3
    } wb_src_e;

endpackage

// File: rtl/eco32f_wb_fifo.sv
// eco32f_wb_fifo: late-result queue for the write-back stage.
// Strict FIFO of QDEPTH entries (power of two, >= 2), pointers wrap
// naturally. Pushes into a full queue and pops from an empty queue are
// ignored. The peek bus lists entries by age (index 0 = oldest) with a
// per-entry valid flag so the parent can search for forwarding matches.
module eco32f_wb_fifo #(
    parameter int W      = 37,
    parameter int QDEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [W-1:0]                  i_wdata,
    input  logic                          i_pop,
    output logic [W-1:0]                  o_head,
    output logic [$clog2(QDEPTH):0]       o_count,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [QDEPTH-1:0][W-1:0]      o_peek_data,
    output logic [QDEPTH-1:0]             o_peek_valid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(QDEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Age-ordered view of the queue contents for the forwarding search.
    always_comb begin
        for (int k = 0; k < QDEPTH; k++) begin
            o_peek_data[k]  = r_mem[PW'(r_rd_ptr + PW'(k))];
            o_peek_valid[k] = (CW'(k) < r_count);
        end
    end

endmodule

// File: rtl/eco32f_writeback_q.sv
// eco32f_writeback_q: write-back stage with a queue for late results.
// One register-file write port shared by exceptions (link write), the
// in-order pipeline result and a FIFO of long-latency results, in that
// priority. Outputs are registered one clock after selection.
// Optional feature: define ECO32F_WB_FWD_EN to build the forwarding lookup
// (hz_addr -> hz_hit/hz_data); otherwise hz_hit and hz_data are tied to 0.
//
// Handshake: a late result is accepted on a rising edge where
// late_valid && late_ready; late_ready depends only on the registered
// queue count, so a full queue refuses a push even while it pops.
module eco32f_writeback_q
    import eco32f_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int AW     = AW_DEFAULT,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          do_exception,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_pc,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] mem_lsu_result,
    input  logic          mem_op_load,
    input  logic          mem_rf_r_we,
    input  logic [AW-1:0] mem_rf_r_addr,
    input  logic          late_valid,
    input  logic [DW-1:0] late_data,
    input  logic [AW-1:0] late_addr,
    output logic          late_ready,
    output logic          wb_drain_req,
    input  logic [AW-1:0] hz_addr,
    output logic          hz_hit,
    output logic [DW-1:0] hz_data,
    output logic [DW-1:0] wb_rf_r,
    output logic          wb_rf_r_we,
    output logic [AW-1:0] wb_rf_r_addr
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = AW + DW;

    wb_src_e                     w_src;
    logic [DW-1:0]               w_sel_data;
    logic [AW-1:0]               w_sel_addr;
    logic [EW-1:0]               w_q_head;
    logic [CW-1:0]               w_q_count;
    logic                        w_q_full;
    logic                        w_q_empty;
    logic                        w_push;
    logic                        w_pop;
    logic [QDEPTH-1:0][EW-1:0]   w_peek_data;
    logic [QDEPTH-1:0]           w_peek_valid;

    logic [DW-1:0] r_wb_data;
    logic [AW-1:0] r_wb_addr;
    logic          r_wb_we;

    assign late_ready   = !w_q_full;
    assign w_push       = late_valid && late_ready;
    assign w_pop        = (w_src == SRC_QUEUE);
    assign wb_drain_req = (w_q_count >= CW'(QDEPTH - 1));

    eco32f_wb_fifo #(
        .W      (EW),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_wdata      ({late_addr, late_data}),
        .i_pop        (w_pop),
        .o_head       (w_q_head),
        .o_count      (w_q_count),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty),
        .o_peek_data  (w_peek_data),
        .o_peek_valid (w_peek_valid)
    );

    // Pick the write-port owner and its address/data for this cycle.
    always_comb begin
        w_src      = SRC_NONE;
        w_sel_data = '0;
        w_sel_addr = '0;
        if (do_exception) begin
            w_src      = SRC_EXC;
            w_sel_data = mem_pc;
            w_sel_addr = AW'(EXC_LINK_REG);
        end else if (!mem_stall && mem_rf_r_we) begin
            w_src      = SRC_PIPE;
            w_sel_data = mem_op_load ? mem_lsu_result : mem_alu_result;
            w_sel_addr = mem_rf_r_addr;
        end else if (!w_q_empty) begin
            w_src      = SRC_QUEUE;
            w_sel_data = w_q_head[DW-1:0];
            w_sel_addr = w_q_head[EW-1:DW];
        end
    end

    // Register the selected write; register 0 is never written, and idle
    // cycles hold address/data with the enable dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_data <= '0;
            r_wb_addr <= '0;
            r_wb_we   <= 1'b0;
        end else if (w_src == SRC_NONE) begin
            r_wb_we   <= 1'b0;
        end else begin
            r_wb_data <= w_sel_data;
            r_wb_addr <= w_sel_addr;
            r_wb_we   <= (w_sel_addr != '0);
        end
    end

    assign wb_rf_r      = r_wb_data;
    assign wb_rf_r_addr = r_wb_addr;
    assign wb_rf_r_we   = r_wb_we;

`ifdef ECO32F_WB_FWD_EN
    // Forwarding search: queued entries commit after the registered write,
    // so they override it, and younger queue entries override older ones.
    always_comb begin
        hz_hit  = 1'b0;
        hz_data = '0;
        if (hz_addr != '0) begin
            if (r_wb_we && (r_wb_addr == hz_addr)) begin
                hz_hit  = 1'b1;
                hz_data = r_wb_data;
            end
            for (int k = 0; k < QDEPTH; k++) begin
                if (w_peek_valid[k] && (w_peek_data[k][EW-1:DW] == hz_addr)) begin
                    hz_hit  = 1'b1;
                    hz_data = w_peek_data[k][DW-1:0];
                end
            end
        end
    end
`else
    logic w_fwd_unused;

    // Lookup not built: outputs tied off, lookup inputs intentionally ignored.
    always_comb begin
        hz_hit  = 1'b0;
        hz_data = '0;
    end
    assign w_fwd_unused = ^{hz_addr, w_peek_data, w_peek_valid};
`endif

endmodule

// File: tb/tb_eco32f_writeback_q.sv
// tb_eco32f_writeback_q: randomized and directed bench for eco32f_writeback_q.
// A queue-based reference model predicts every registered write one cycle
// ahead; a monitor pops predictions and compares each cycle.
module tb_eco32f_writeback_q;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int QD = 4;
    localparam int W  = AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          do_exception = 1'b0;
    logic          mem_stall = 1'b0;
    logic [DW-1:0] mem_pc = '0;
    logic [DW-1:0] mem_alu_result = '0;
    logic [DW-1:0] mem_lsu_result = '0;
    logic          mem_op_load = 1'b0;
    logic          mem_rf_r_we = 1'b0;
    logic [AW-1:0] mem_rf_r_addr = '0;
    logic          late_valid = 1'b0;
    logic [DW-1:0] late_data = '0;
    logic [AW-1:0] late_addr = '0;
    logic          late_ready;
    logic          wb_drain_req;
    logic [AW-1:0] hz_addr = '0;
    logic          hz_hit;
    logic [DW-1:0] hz_data;
    logic [DW-1:0] wb_rf_r;
    logic          wb_rf_r_we;
    logic [AW-1:0] wb_rf_r_addr;

    eco32f_writeback_q #(.DW(DW), .AW(AW), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .do_exception   (do_exception),
        .mem_stall      (mem_stall),
        .mem_pc         (mem_pc),
        .mem_alu_result (mem_alu_result),
        .mem_lsu_result (mem_lsu_result),
        .mem_op_load    (mem_op_load),
        .mem_rf_r_we    (mem_rf_r_we),
        .mem_rf_r_addr  (mem_rf_r_addr),
        .late_valid     (late_valid),
        .late_data      (late_data),
        .late_addr      (late_addr),
        .late_ready     (late_ready),
        .wb_drain_req   (wb_drain_req),
        .hz_addr        (hz_addr),
        .hz_hit         (hz_hit),
        .hz_data        (hz_data),
        .wb_rf_r        (wb_rf_r),
        .wb_rf_r_we     (wb_rf_r_we),
        .wb_rf_r_addr   (wb_rf_r_addr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0]   exp_q[$];   // {we, addr, data} expected after each driven edge
    logic [W-1:0] late_m[$];  // model of queued late results, oldest first
    logic          last_we   = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [W:0]    mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (wb_rf_r_we !== mon_e[W]) begin
                n_fail++;
                $display("FAIL wb_we: got %b, expected %b (exp addr %0d data 0x%08h)",
                         wb_rf_r_we, mon_e[W], mon_e[W-1:DW], mon_e[DW-1:0]);
            end else if (mon_e[W] && ({wb_rf_r_addr, wb_rf_r} !== mon_e[W-1:0])) begin
                n_fail++;
                $display("FAIL wb_write: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                         wb_rf_r_addr, wb_rf_r, mon_e[W-1:DW], mon_e[DW-1:0]);
            end
        end else if (!rst && wb_rf_r_we === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got write addr %0d data 0x%08h, expected no write",
                     wb_rf_r_addr, wb_rf_r);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit exc, input bit stall, input bit load, input bit rwe,
                         input logic [AW-1:0] raddr, input logic [DW-1:0] pc,
                         input logic [DW-1:0] alu, input logic [DW-1:0] lsu,
                         input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic [AW-1:0] ha);
        bit            sel;
        bit            rdy;
        bit            m_hit;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] m_data;
        @(negedge clk);
        #1;
        // Checks on state left by the previous edge.
        check("late_ready", late_ready, late_m.size() < QD);
        check("wb_drain_req", wb_drain_req, late_m.size() >= QD - 1);
        m_hit  = 1'b0;
        m_data = '0;
`ifdef ECO32F_WB_FWD_EN
        if (hz_addr != '0) begin
            if (last_we && last_addr == hz_addr) begin
                m_hit  = 1'b1;
                m_data = last_data;
            end
            foreach (late_m[i]) begin
                if (late_m[i][W-1:DW] == hz_addr) begin
                    m_hit  = 1'b1;
                    m_data = late_m[i][DW-1:0];
                end
            end
        end
`endif
        check("hz_hit", hz_hit, m_hit);
        check("hz_data", hz_data, m_hit ? m_data : '0);
        // Apply new inputs.
        do_exception   = exc;
        mem_stall      = stall;
        mem_op_load    = load;
        mem_rf_r_we    = rwe;
        mem_rf_r_addr  = raddr;
        mem_pc         = pc;
        mem_alu_result = alu;
        mem_lsu_result = lsu;
        late_valid     = lv;
        late_addr      = la;
        late_data      = ld;
        hz_addr        = ha;
        // Reference model for this edge.
        rdy = (late_m.size() < QD);
        sel = 1'b1;
        a   = '0;
        d   = '0;
        if (exc) begin
            a = AW'(30);
            d = pc;
        end else if (!stall && rwe) begin
            a = raddr;
            d = load ? lsu : alu;
        end else if (late_m.size() > 0) begin
            {a, d} = late_m.pop_front();
        end else begin
            sel = 1'b0;
        end
        exp_q.push_back({sel && (a != 0), a, d});
        if (sel) begin
            last_we   = (a != 0);
            last_addr = a;
            last_data = d;
        end else begin
            last_we = 1'b0;
        end
        if (lv && rdy) late_m.push_back({la, ld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    // Pipeline keeps the write port busy while a late result is offered.
    task automatic busy_push(input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic [AW-1:0] ha);
        drive(0, 0, 0, 1, AW'(9), '0, $urandom, '0, 1, la, ld, ha);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        do_exception = 0; mem_stall = 0; mem_rf_r_we = 0; late_valid = 0; hz_addr = '0;
        exp_q.delete();
        late_m.delete();
        last_we = 1'b0;
        #1;
        check("rst_wb_we", wb_rf_r_we, 0);
        check("rst_wb_addr", wb_rf_r_addr, 0);
        check("rst_wb_data", wb_rf_r, 0);
        check("rst_late_ready", late_ready, 1);
        check("rst_drain", wb_drain_req, 0);
        check("rst_hz_hit", hz_hit, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        // Exception during stall writes the link register.
        drive(1, 1, 0, 1, AW'(3), 32'h0000_1234, 32'h5, 32'h6, 0, '0, '0, '0);
        idle(1);

        // Load result, then the same to r0 (suppressed).
        drive(0, 0, 1, 1, AW'(5), '0, 32'h1, 32'hDEAD_BEEF, 0, '0, '0, '0);
        drive(0, 0, 1, 1, AW'(0), '0, 32'h1, 32'hDEAD_BEEF, 0, '0, '0, '0);
        idle(1);

        // Fill queue while the pipeline writes every cycle, then drain.
        for (int i = 1; i <= 4; i++) busy_push(AW'(i), DW'(32'h11 * i), '0);
        busy_push(AW'(6), 32'h66, '0);   // refused: queue full
        idle(6);

        // Full queue, offer a push in a pop cycle: refused, count drops to 3.
        for (int i = 1; i <= 4; i++) busy_push(AW'(10 + i), DW'(i), '0);
        drive(0, 0, 0, 0, '0, '0, '0, '0, 1, AW'(20), 32'h20, '0);
        idle(5);

        // Two queued results to the same register; newest should forward.
        busy_push(AW'(7), 32'hA, AW'(7));
        busy_push(AW'(7), 32'hB, AW'(7));
        drive(0, 0, 0, 1, AW'(9), '0, 32'h99, '0, 0, '0, '0, AW'(7));
        idle(4);

        // Exception does not flush queued results.
        busy_push(AW'(21), 32'h21, '0);
        drive(1, 0, 0, 1, AW'(2), 32'h400, '0, '0, 0, '0, '0, '0);
        idle(3);

        // Reset mid-operation discards queue and in-flight write.
        for (int i = 1; i <= 3; i++) busy_push(AW'(i), DW'(i), '0);
        do_reset();
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom,
                  AW'($urandom_range(0, 31)));
        end
        idle(8);

        @(negedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
